pong_game_ctrl: RTL and testbench

Game-level controller for the Pong datapath. It consumes the ball position from the ball-motion stage and both paddle positions, detects misses at the left and right goal columns, and keeps per-player scores. It drives the game-on enable back into the ball and paddle stages, which recentre the ball whenever that enable is low, and it declares a winner at the score limit.

---
 rtl/pong_pkg.sv | 21 ++
 rtl/pong_start_edge.sv | 33 +++
 rtl/pong_game_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: controller state encoding, coordinate/score widths
// and the default playfield geometry used by the ball, paddle and game stages.
package pong_pkg;

    localparam int unsigned COORD_W       = 6;
    localparam int unsigned SCORE_W       = 4;

    localparam int unsigned GAME_WIDTH    = 40;
    localparam int unsigned GAME_HEIGHT   = 30;
    localparam int unsigned PADDLE_HEIGHT = 6;
    localparam int unsigned SCORE_LIMIT   = 9;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RUNNING    = 3'd1,
        ST_POINT      = 3'd2,
        ST_SERVE_WAIT = 3'd3,
        ST_GAME_OVER  = 3'd4
    } game_state_e;

endpackage

// File: rtl/pong_start_edge.sv
// Start button edge detector: registers the (already debounced) start level and
// emits a registered one-cycle pulse when it is sampled high after being low.
// Ports:
//   i_Clk, i_Rst   clock, asynchronous active-high reset
//   i_Start        start button level
//   o_Start_Pulse  one-cycle registered rising-edge pulse
module pong_start_edge (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Start,
    output logic o_Start_Pulse
);

    logic start_q;
    logic pulse_q;
    logic pulse_d;

    assign pulse_d = i_Start & ~start_q;

    // Start history and pulse registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            start_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            start_q <= i_Start;
            pulse_q <= pulse_d;
        end
    end

    assign o_Start_Pulse = pulse_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-level controller: detects misses at the goal columns, keeps both
// scores, gates the ball/paddle stages with o_Game_On and declares the winner.
// Optional feature macro: PONG_AUTO_SERVE_EN (serve automatically after a
// non-final point instead of waiting for a new start edge).
// Ports:
//   i_Clk, i_Rst                 clock, asynchronous active-high reset
//   i_Start                      debounced start level
//   i_Ball_X, i_Ball_Y           ball position in tiles
//   i_Paddle_Y_P1, i_Paddle_Y_P2 top row of left / right paddle
//   o_Game_On                    ball/paddle enable (high only while running)
//   o_P1_Score, o_P2_Score       per-player scores
//   o_Game_Over, o_Winner        winner declared / which player (1 = P2)
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned c_GAME_WIDTH    = GAME_WIDTH,
    parameter int unsigned c_GAME_HEIGHT   = GAME_HEIGHT,
    parameter int unsigned c_PADDLE_HEIGHT = PADDLE_HEIGHT,
    parameter int unsigned c_SCORE_LIMIT   = SCORE_LIMIT,
    parameter int unsigned c_SERVE_DLY     = 50000000
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Start,
    input  logic [COORD_W-1:0] i_Ball_X,
    input  logic [COORD_W-1:0] i_Ball_Y,
    input  logic [COORD_W-1:0] i_Paddle_Y_P1,
    input  logic [COORD_W-1:0] i_Paddle_Y_P2,
    output logic               o_Game_On,
    output logic [SCORE_W-1:0] o_P1_Score,
    output logic [SCORE_W-1:0] o_P2_Score,
    output logic               o_Game_Over,
    output logic               o_Winner
);

    // Paddle bounds are one bit wider so a paddle near the bottom never wraps.
    localparam int unsigned YEXT_W = COORD_W + 1;

    // Reject parameter sets the datapath widths cannot represent.
    if (c_SCORE_LIMIT < 1 || c_SCORE_LIMIT > 15 || c_SERVE_DLY < 1 ||
        c_PADDLE_HEIGHT < 1 || c_GAME_WIDTH < 2 || c_GAME_WIDTH > 64 ||
        c_GAME_HEIGHT > 64) begin : g_bad_cfg
        $error("pong_game_ctrl: parameter out of range");
    end

    logic start_pulse;

    pong_start_edge u_start_edge (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_Start       (i_Start),
        .o_Start_Pulse (start_pulse)
    );

    // Miss detection; P1 takes priority in the FSM.
    logic [YEXT_W-1:0] p1_hi_c;
    logic [YEXT_W-1:0] p2_hi_c;
    logic              miss_p1_c;
    logic              miss_p2_c;

    assign p1_hi_c   = {1'b0, i_Paddle_Y_P1} + YEXT_W'(c_PADDLE_HEIGHT - 1);
    assign p2_hi_c   = {1'b0, i_Paddle_Y_P2} + YEXT_W'(c_PADDLE_HEIGHT - 1);
    assign miss_p1_c = (i_Ball_X == '0) &&
                       ((i_Ball_Y < i_Paddle_Y_P1) || ({1'b0, i_Ball_Y} > p1_hi_c));
    assign miss_p2_c = (i_Ball_X == COORD_W'(c_GAME_WIDTH - 1)) &&
                       ((i_Ball_Y < i_Paddle_Y_P2) || ({1'b0, i_Ball_Y} > p2_hi_c));

    game_state_e        state_q, state_d;
    logic [SCORE_W-1:0] p1_q, p1_d;
    logic [SCORE_W-1:0] p2_q, p2_d;
    logic               over_q, over_d;
    logic               winner_q, winner_d;
    logic               game_on_q, game_on_d;
    logic               at_limit_c;

    assign at_limit_c = (p1_q == SCORE_W'(c_SCORE_LIMIT)) ||
                        (p2_q == SCORE_W'(c_SCORE_LIMIT));

`ifdef PONG_AUTO_SERVE_EN
    localparam int unsigned CNT_W = (c_SERVE_DLY > 1) ? $clog2(c_SERVE_DLY) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // State, score and output registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= ST_IDLE;
            p1_q      <= '0;
            p2_q      <= '0;
            over_q    <= 1'b0;
            winner_q  <= 1'b0;
            game_on_q <= 1'b0;
`ifdef PONG_AUTO_SERVE_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            over_q    <= over_d;
            winner_q  <= winner_d;
            game_on_q <= game_on_d;
`ifdef PONG_AUTO_SERVE_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        over_d   = over_q;
        winner_d = winner_q;
`ifdef PONG_AUTO_SERVE_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_pulse) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (miss_p1_c) begin
                    p2_d    = p2_q + SCORE_W'(1);
                    state_d = ST_POINT;
                end else if (miss_p2_c) begin
                    p1_d    = p1_q + SCORE_W'(1);
                    state_d = ST_POINT;
                end
            end
            ST_POINT: begin
                if (at_limit_c) begin
                    state_d  = ST_GAME_OVER;
                    over_d   = 1'b1;
                    winner_d = (p2_q == SCORE_W'(c_SCORE_LIMIT));
                end else begin
`ifdef PONG_AUTO_SERVE_EN
                    state_d = ST_SERVE_WAIT;
                    cnt_d   = '0;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef PONG_AUTO_SERVE_EN
            ST_SERVE_WAIT: begin
                if (cnt_q == CNT_W'(c_SERVE_DLY - 1)) state_d = ST_RUNNING;
                else cnt_d = cnt_q + CNT_W'(1);
            end
`endif
            ST_GAME_OVER: begin
                if (start_pulse) begin
                    state_d  = ST_RUNNING;
                    p1_d     = '0;
                    p2_d     = '0;
                    over_d   = 1'b0;
                    winner_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        game_on_d = (state_d == ST_RUNNING);
    end

    assign o_Game_On   = game_on_q;
    assign o_P1_Score  = p1_q;
    assign o_P2_Score  = p2_q;
    assign o_Game_Over = over_q;
    assign o_Winner    = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: event-level game model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_pong_game_ctrl;

    localparam int W   = 40;
    localparam int H   = 6;
    localparam int LIM = 9;
    localparam int DLY = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] bx = 6'd20;
    logic [5:0] by = 6'd15;
    logic [5:0] py1 = 6'd12;
    logic [5:0] py2 = 6'd12;
    logic       on;
    logic [3:0] s1;
    logic [3:0] s2;
    logic       over;
    logic       win;

    int total = 0;
    int bad   = 0;

    pong_game_ctrl #(
        .c_GAME_WIDTH    (W),
        .c_GAME_HEIGHT   (30),
        .c_PADDLE_HEIGHT (H),
        .c_SCORE_LIMIT   (LIM),
        .c_SERVE_DLY     (DLY)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Start       (start),
        .i_Ball_X      (bx),
        .i_Ball_Y      (by),
        .i_Paddle_Y_P1 (py1),
        .i_Paddle_Y_P2 (py2),
        .o_Game_On     (on),
        .o_P1_Score    (s1),
        .o_P2_Score    (s2),
        .o_Game_Over   (over),
        .o_Winner      (win)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Game model: tracks the observable game in terms of events
    // (start edges, misses, countdown until play resumes).
    int m_prev = 0, m_pulse = 0, m_on = 0, m_p1 = 0, m_p2 = 0;
    int m_over = 0, m_win = 0, m_final = 0, m_off = 0, m_ready = 1, m_pn = 0;

    task automatic model_point();
        m_on = 0;
        if (m_p1 == LIM || m_p2 == LIM) m_final = 1;
`ifdef PONG_AUTO_SERVE_EN
        else m_off = DLY + 1;
`else
        else m_off = 1;
`endif
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev = 0; m_pulse = 0; m_on = 0; m_p1 = 0; m_p2 = 0;
            m_over = 0; m_win = 0; m_final = 0; m_off = 0; m_ready = 1;
        end else begin
            m_pn    = m_pulse;
            m_pulse = (start && m_prev == 0) ? 1 : 0;
            m_prev  = int'(start);
            if (m_final != 0) begin
                m_final = 0; m_over = 1; m_win = (m_p2 == LIM) ? 1 : 0; m_ready = 1;
            end else if (m_on != 0) begin
                if (bx == 0 && (int'(by) < int'(py1) || int'(by) > int'(py1) + H - 1)) begin
                    m_p2++; model_point();
                end else if (int'(bx) == W - 1 &&
                             (int'(by) < int'(py2) || int'(by) > int'(py2) + H - 1)) begin
                    m_p1++; model_point();
                end
            end else if (m_off > 0) begin
                m_off--;
`ifdef PONG_AUTO_SERVE_EN
                if (m_off == 0) m_on = 1;
`else
                if (m_off == 0) m_ready = 1;
`endif
            end else if (m_pn != 0 && m_ready != 0) begin
                if (m_over != 0) begin m_p1 = 0; m_p2 = 0; m_over = 0; m_win = 0; end
                m_on = 1; m_ready = 0;
            end
        end
    end

    // Cycle compare against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_game_on", 8'(on), 8'(m_on));
            chk("model_p1", 8'(s1), 8'(m_p1));
            chk("model_p2", 8'(s2), 8'(m_p2));
            chk("model_over", 8'(over), 8'(m_over));
            if (m_over != 0) chk("model_winner", 8'(win), 8'(m_win));
        end
    end

    task automatic wait_on(input string nm);
        int k;
        k = 0;
        while (!on && k < 30) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (!on) begin
            bad++;
            $display("FAIL %s: game_on still %0d after %0d cycles, expected 1", nm, on, k);
        end
    endtask

    task automatic press_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bring the game back to running after a point.
    task automatic resume(input string nm);
        if (!on) begin
            repeat (2) @(negedge clk);
`ifndef PONG_AUTO_SERVE_EN
            press_start();
`endif
            wait_on(nm);
        end
    endtask

    task automatic miss(input bit right);
        bx = right ? 6'(W - 1) : 6'd0;
        by = right ? 6'd30 : 6'd10;
        @(negedge clk);
        bx = 6'd20;
        by = 6'd15;
    endtask

    initial begin
        int low;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_on", 8'(on), 8'd0);
        chk("rst_p1", 8'(s1), 8'd0);
        chk("rst_p2", 8'(s2), 8'd0);
        chk("rst_over", 8'(over), 8'd0);
        chk("rst_win", 8'(win), 8'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Start: game_on rises two edges after start is sampled high.
        start = 1'b1;
        @(negedge clk);
        chk("start_k", 8'(on), 8'd0);
        @(negedge clk);
        chk("start_k1", 8'(on), 8'd1);
        chk("start_scores", 8'({s1, s2}), 8'h00);
        start = 1'b0;

        // Last covered paddle row: no miss.
        bx = 6'd0; by = 6'd17;
        @(negedge clk);
        chk("edge_row_on", 8'(on), 8'd1);
        chk("edge_row_p2", 8'(s2), 8'd0);

        // Miss above the paddle: P2 scores, play stops.
        bx = 6'd0; by = 6'd10;
        @(negedge clk);
        bx = 6'd20; by = 6'd15;
        chk("miss_p2", 8'(s2), 8'd1);
        chk("miss_on", 8'(on), 8'd0);

`ifdef PONG_AUTO_SERVE_EN
        low = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (on) break;
            low++;
        end
        chk("serve_low_cycles", 8'(low), 8'(DLY + 1));
        chk("serve_on", 8'(on), 8'd1);
`else
        low = 0;
        repeat (8) @(negedge clk);
        chk("no_serve_on", 8'(on), 8'd0);
        press_start();
        wait_on("restart");
`endif

        // Paddle near the bottom must not wrap its covered range.
        py2 = 6'd60; bx = 6'(W - 1); by = 6'd62;
        @(negedge clk);
        chk("wrap_on", 8'(on), 8'd1);
        chk("wrap_p1", 8'(s1), 8'd0);
        py2 = 6'd12; bx = 6'd20; by = 6'd15;

        // P1 wins at the limit.
        for (int i = 0; i < LIM; i++) begin
            resume("resume_p1");
            miss(1'b1);
        end
        chk("p1_limit", 8'(s1), 8'd9);
        @(negedge clk);
        chk("over_set", 8'(over), 8'd1);
        chk("over_winner", 8'(win), 8'd0);
        chk("over_on", 8'(on), 8'd0);
        repeat (2) @(negedge clk);
        press_start();
        wait_on("new_game");
        chk("new_game_scores", 8'({s1, s2}), 8'h00);
        chk("new_game_over", 8'(over), 8'd0);

        // Reach 3/2 then reset asynchronously mid-cycle.
        for (int i = 0; i < 3; i++) begin resume("r1"); miss(1'b1); end
        for (int i = 0; i < 2; i++) begin resume("r2"); miss(1'b0); end
        resume("r3");
        chk("pre_rst_scores", 8'({s1, s2}), 8'h32);
        #2 rst = 1'b1;
        #1;
        chk("async_on", 8'(on), 8'd0);
        chk("async_p1", 8'(s1), 8'd0);
        chk("async_p2", 8'(s2), 8'd0);
        chk("async_over", 8'(over), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", 8'(on), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
